execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the 5-stage pipelined Y86-64 processor, between decode/writeback and data memory. Computes valE with a 64-bit ALU, holds the condition codes (CC), evaluates branch/conditional-move conditions and owns the E→M pipeline register. Its combinational outputs feed forwarding, pipeline control and fetch misprediction recovery.

## Interface
No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- E_stat  in  4 [0:3]  status: AOK=1000, HLT=0100, ADR=0010, INS=0001
- E_icode, E_ifun  in  4  instruction code/function
- E_valA, E_valB, E_valC  in  64 signed  operands
- E_destE, E_destM  in  4  destination register IDs (F = none)
- setcc  in  1  CC write enable from pipeline control
- e_valE  out  64 signed  combinational ALU result
- e_destE  out  4  combinational destE (cancelled for untaken cmov)
- e_Cnd  out  1  combinational condition result
- M_stat  out  4; M_icode  out  4; M_Cnd  out  1; M_valE, M_valA  out  64 signed; M_destE, M_destM  out  4 — E→M register
- cc_in  out  3  current CC {OF,SF,ZF}

## Operation
- ALU result e_valE by icode:
  - 2 rrmovq/cmovXX: valA+0
  - 3 irmovq: valC+0
  - 4/5 rmmovq/mrmovq: valB+valC
  - 6 OPq: valB op valA; ifun 0 add, 1 sub (valB−valA), 2 and, 3 xor, other ifun → 0
  - 8/A call/pushq: valB−8
  - 9/B ret/popq: valB+8
  - all others: 0
- Arithmetic is 64-bit two's complement; carry out discarded.
- CC write happens only when E_icode==6 && setcc:
  - ZF = (result==0); SF = result[63].
  - OF for add: operands have the same sign and result sign differs.
  - OF for sub: valB and valA signs differ and result sign ≠ valB sign.
  - OF for and/xor: 0.
- Condition from CC by ifun:
  - 0 always; 1 le (SF^OF)|ZF; 2 l SF^OF; 3 e ZF; 4 ne !ZF; 5 ge !(SF^OF); 6 g !(SF^OF)&!ZF
  - ifun > 6 → 0
- e_Cnd = condition for icode 2 and 7; 0 for all other icodes.
- e_destE = F when icode==2 && !e_Cnd, otherwise E_destE.
- E_valA passes unchanged to M_valA.
- Status does not gate computation. A non-AOK E_stat is carried forward unchanged.

## Timing
- e_valE, e_Cnd, e_destE: combinational, zero latency.
- Condition evaluation uses the registered CC. An OPq writes CC at the edge it leaves E, so an instruction immediately following it sees the new flags.
- Each posedge: M_stat←E_stat, M_icode←E_icode, M_Cnd←e_Cnd, M_valE←e_valE, M_valA←E_valA, M_destE←e_destE, M_destM←E_destM. Latency is 1 cycle. No stall or bubble input; control inserts bubbles upstream.
- Reset (priority over setcc and all loads):
  - CC = {OF=0, SF=0, ZF=1}, so cc_in=001
  - M_stat = 1000, M_icode = 1 (nop), M_Cnd = 0, M_valE = M_valA = 0, M_destE = M_destM = F
- Reset asserted mid-operation discards the in-flight M contents on that edge.

## Configuration
- EXECUTE_TRACE_EN defined: each posedge, $display of E_icode, E_ifun, e_valE, e_Cnd, e_destE and CC.
- Undefined: no trace code is compiled.
- Functional behaviour is identical either way.

## Structure
- Shared package y86_pkg holds:
  - icode constants (HALT..POPQ)
  - ALU ifun constants (ADD, SUB, AND, XOR)
  - condition ifun constants
  - stat codes (AOK, HLT, ADR, INS)
  - RNONE = 4'hF
- One sub-module, y86_alu: inputs a, b, ifun; outputs result and the {OF,SF,ZF} candidate.
- Operand muxing, CC register, condition logic and the M register live in execute_stage.

## Test plan
- OPq add, icode 6 ifun 0, valA=5, valB=7, setcc=1 → e_valE=12; after the edge cc_in=000 and M_valE=12.
- OPq sub, valB=3, valA=3 → e_valE=0, CC becomes ZF=1. A following je (icode 7, ifun 3) → e_Cnd=1, then jne → e_Cnd=0.
- Overflow: add 0x7FFF_FFFF_FFFF_FFFF + 1 → e_valE=0x8000_0000_0000_0000, cc_in=110. Repeat with setcc=0 → CC unchanged.
- cmovle (icode 2, ifun 1) with CC=000, E_destE=3 → e_Cnd=0, e_destE=F. rrmovq (ifun 0), valA=9 → e_valE=9, e_destE=3.
- pushq valB=100 → e_valE=92; popq valB=100 → e_valE=108; rmmovq valB=2, valC=1 → e_valE=3.
- Assert rst while M holds an OPq → next cycle M_icode=1, M_stat=1000, M_destE=F, cc_in=001. E_stat=0100 propagates to M_stat after one edge.

Source files
------------

// File: rtl/y86_pkg.sv
// ============================================================================
// Module      : y86_pkg
// Description : Shared Y86-64 encodings: icodes, ALU/condition ifuns, status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package y86_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_CMOVXX = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [3:0] STAT_AOK = 4'b1000;
    localparam logic [3:0] STAT_HLT = 4'b0100;
    localparam logic [3:0] STAT_ADR = 4'b0010;
    localparam logic [3:0] STAT_INS = 4'b0001;

    localparam logic [3:0] RNONE = 4'hF;

    // CC reset value {OF,SF,ZF}
    localparam logic [2:0] CC_RESET = 3'b001;

endpackage

`default_nettype wire

// File: rtl/execute_stage_if.sv
// ============================================================================
// Module      : execute_stage_if
// Description : E-stage inputs, combinational e_* outputs and E->M register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface execute_stage_if;

    logic [3:0]         E_stat;
    logic [3:0]         E_icode;
    logic [3:0]         E_ifun;
    logic signed [63:0] E_valA;
    logic signed [63:0] E_valB;
    logic signed [63:0] E_valC;
    logic [3:0]         E_destE;
    logic [3:0]         E_destM;
    logic               setcc;

    logic signed [63:0] e_valE;
    logic [3:0]         e_destE;
    logic               e_Cnd;

    logic [3:0]         M_stat;
    logic [3:0]         M_icode;
    logic               M_Cnd;
    logic signed [63:0] M_valE;
    logic signed [63:0] M_valA;
    logic [3:0]         M_destE;
    logic [3:0]         M_destM;
    logic [2:0]         cc_in;

    modport master (
        output E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC,
               E_destE, E_destM, setcc,
        input  e_valE, e_destE, e_Cnd,
               M_stat, M_icode, M_Cnd, M_valE, M_valA, M_destE, M_destM, cc_in
    );

    modport slave (
        input  E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC,
               E_destE, E_destM, setcc,
        output e_valE, e_destE, e_Cnd,
               M_stat, M_icode, M_Cnd, M_valE, M_valA, M_destE, M_destM, cc_in
    );

endinterface

`default_nettype wire

// File: rtl/y86_alu.sv
// ============================================================================
// Module      : y86_alu
// Description : 64-bit Y86 ALU computing b op a plus candidate {OF,SF,ZF}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module y86_alu
    import y86_pkg::*;
(
    input  wire logic [63:0] a,
    input  wire logic [63:0] b,
    input  wire logic [3:0]  ifun,
    output logic      [63:0] result,
    output logic      [2:0]  flags
);

    logic [63:0] sum;
    logic [63:0] diff;
    logic        of;

    assign sum  = b + a;
    assign diff = b - a;

    always_comb begin
        result = 64'd0;
        of     = 1'b0;
        case (ifun)
            ALU_ADD: begin
                result = sum;
                of     = (a[63] == b[63]) && (sum[63] != a[63]);
            end
            ALU_SUB: begin
                result = diff;
                of     = (a[63] != b[63]) && (diff[63] != b[63]);
            end
            ALU_AND: result = b & a;
            ALU_XOR: result = b ^ a;
            default: result = 64'd0;
        endcase
    end

    assign flags = {of, result[63], (result == 64'd0)};

endmodule

`default_nettype wire

// File: rtl/execute_stage.sv
// ============================================================================
// Module      : execute_stage
// Description : Y86-64 execute stage: operand mux, ALU, CC, condition, E->M reg.
//               Optional per-cycle trace when EXECUTE_TRACE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_stage
    import y86_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     rst,
    execute_stage_if.slave ex
);

    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [3:0]  alu_fun;
    logic [63:0] alu_result;
    logic [2:0]  alu_flags;
    logic [2:0]  cc;
    logic        cond;
    logic        of_x_sf;

    // Every non-OPq icode is expressed as an add/sub of a selected operand pair
    always_comb begin
        alu_a   = 64'd0;
        alu_b   = 64'd0;
        alu_fun = ALU_ADD;
        case (ex.E_icode)
            ICODE_CMOVXX: alu_a = ex.E_valA;
            ICODE_IRMOVQ: alu_a = ex.E_valC;
            ICODE_RMMOVQ, ICODE_MRMOVQ: begin
                alu_a = ex.E_valC;
                alu_b = ex.E_valB;
            end
            ICODE_OPQ: begin
                alu_a   = ex.E_valA;
                alu_b   = ex.E_valB;
                alu_fun = ex.E_ifun;
            end
            ICODE_CALL, ICODE_PUSHQ: begin
                alu_a   = 64'd8;
                alu_b   = ex.E_valB;
                alu_fun = ALU_SUB;
            end
            ICODE_RET, ICODE_POPQ: begin
                alu_a = 64'd8;
                alu_b = ex.E_valB;
            end
            default: ;
        endcase
    end

    y86_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .ifun   (alu_fun),
        .result (alu_result),
        .flags  (alu_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cc <= CC_RESET;
        end else if (ex.setcc && (ex.E_icode == ICODE_OPQ)) begin
            cc <= alu_flags;
        end
    end

    assign of_x_sf = cc[2] ^ cc[1];

    always_comb begin
        cond = 1'b0;
        case (ex.E_ifun)
            C_YES:   cond = 1'b1;
            C_LE:    cond = of_x_sf | cc[0];
            C_L:     cond = of_x_sf;
            C_E:     cond = cc[0];
            C_NE:    cond = ~cc[0];
            C_GE:    cond = ~of_x_sf;
            C_G:     cond = ~of_x_sf & ~cc[0];
            default: cond = 1'b0;
        endcase
    end

    assign ex.e_valE  = alu_result;
    assign ex.e_Cnd   = ((ex.E_icode == ICODE_CMOVXX) || (ex.E_icode == ICODE_JXX)) ? cond : 1'b0;
    assign ex.e_destE = ((ex.E_icode == ICODE_CMOVXX) && !ex.e_Cnd) ? RNONE : ex.E_destE;
    assign ex.cc_in   = cc;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex.M_stat  <= STAT_AOK;
            ex.M_icode <= ICODE_NOP;
            ex.M_Cnd   <= 1'b0;
            ex.M_valE  <= 64'sd0;
            ex.M_valA  <= 64'sd0;
            ex.M_destE <= RNONE;
            ex.M_destM <= RNONE;
        end else begin
            ex.M_stat  <= ex.E_stat;
            ex.M_icode <= ex.E_icode;
            ex.M_Cnd   <= ex.e_Cnd;
            ex.M_valE  <= ex.e_valE;
            ex.M_valA  <= ex.E_valA;
            ex.M_destE <= ex.e_destE;
            ex.M_destM <= ex.E_destM;
        end
    end

`ifdef EXECUTE_TRACE_EN
    always @(posedge clk) begin
        $display("EX icode=%h ifun=%h valE=%h Cnd=%b destE=%h CC=%b",
                 ex.E_icode, ex.E_ifun, ex.e_valE, ex.e_Cnd, ex.e_destE, cc);
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
// ============================================================================
// Module      : tb_execute_stage
// Description : Directed self-checking bench for execute_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_execute_stage;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    execute_stage_if ex_if ();

    execute_stage u_dut (
        .clk (clk),
        .rst (rst),
        .ex  (ex_if)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [63:0] va, input logic [63:0] vb,
                         input logic [63:0] vc, input logic [3:0] de,
                         input logic sc);
        ex_if.E_icode = icode;
        ex_if.E_ifun  = ifun;
        ex_if.E_valA  = va;
        ex_if.E_valB  = vb;
        ex_if.E_valC  = vc;
        ex_if.E_destE = de;
        ex_if.setcc   = sc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ex_if.E_stat  = 4'b1000;
        ex_if.E_destM = 4'hF;
        drive(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h2, 1'b1);
        tick();
        tick();
        check("rst_cc",     {61'd0, ex_if.cc_in},   64'd1);
        check("rst_stat",   {60'd0, ex_if.M_stat},  64'h8);
        check("rst_icode",  {60'd0, ex_if.M_icode}, 64'h1);
        check("rst_cnd",    {63'd0, ex_if.M_Cnd},   64'd0);
        check("rst_valE",   ex_if.M_valE,           64'd0);
        check("rst_valA",   ex_if.M_valA,           64'd0);
        check("rst_destE",  {60'd0, ex_if.M_destE}, 64'hF);
        check("rst_destM",  {60'd0, ex_if.M_destM}, 64'hF);
        rst = 1'b0;

        // add 7+5
        drive(4'h6, 4'h0, 64'd5, 64'd7, 64'd0, 4'h2, 1'b1);
        check("add_valE", ex_if.e_valE, 64'd12);
        check("add_cnd",  {63'd0, ex_if.e_Cnd}, 64'd0);
        tick();
        check("add_cc",    {61'd0, ex_if.cc_in},   64'd0);
        check("add_MvalE", ex_if.M_valE,           64'd12);
        check("add_MvalA", ex_if.M_valA,           64'd5);
        check("add_Micode",{60'd0, ex_if.M_icode}, 64'h6);
        check("add_MdestE",{60'd0, ex_if.M_destE}, 64'h2);

        // sub 3-3 -> ZF
        drive(4'h6, 4'h1, 64'd3, 64'd3, 64'd0, 4'h2, 1'b1);
        check("sub_valE", ex_if.e_valE, 64'd0);
        tick();
        check("sub_cc", {61'd0, ex_if.cc_in}, 64'b001);

        drive(4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0);
        check("je_cnd", {63'd0, ex_if.e_Cnd}, 64'd1);
        tick();
        check("je_MCnd", {63'd0, ex_if.M_Cnd}, 64'd1);
        drive(4'h7, 4'h4, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0);
        check("jne_cnd", {63'd0, ex_if.e_Cnd}, 64'd0);
        tick();

        // signed overflow on add
        drive(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h2, 1'b1);
        check("ovf_valE", ex_if.e_valE, 64'h8000_0000_0000_0000);
        tick();
        check("ovf_cc", {61'd0, ex_if.cc_in}, 64'b110);
        drive(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0);
        check("jl_ovf", {63'd0, ex_if.e_Cnd}, 64'd0);
        drive(4'h7, 4'h5, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0);
        check("jge_ovf", {63'd0, ex_if.e_Cnd}, 64'd1);

        // setcc=0 keeps CC even though flags would be 001
        drive(4'h6, 4'h0, 64'd0, 64'd0, 64'd0, 4'h2, 1'b0);
        tick();
        check("nosetcc_cc", {61'd0, ex_if.cc_in}, 64'b110);

        // sub overflow: min - 1
        drive(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 4'h2, 1'b1);
        check("subovf_valE", ex_if.e_valE, 64'h7FFF_FFFF_FFFF_FFFF);
        tick();
        check("subovf_cc", {61'd0, ex_if.cc_in}, 64'b100);

        drive(4'h6, 4'h2, 64'h3C, 64'hF0, 64'd0, 4'h2, 1'b0);
        check("and_valE", ex_if.e_valE, 64'h30);
        drive(4'h6, 4'h3, 64'h3C, 64'hF0, 64'd0, 4'h2, 1'b0);
        check("xor_valE", ex_if.e_valE, 64'hCC);
        drive(4'h6, 4'h5, 64'h3C, 64'hF0, 64'd0, 4'h2, 1'b0);
        check("badop_valE", ex_if.e_valE, 64'd0);

        // CC back to 000
        drive(4'h6, 4'h0, 64'd5, 64'd7, 64'd0, 4'h2, 1'b1);
        tick();
        check("cc_000", {61'd0, ex_if.cc_in}, 64'd0);

        drive(4'h2, 4'h1, 64'd9, 64'd0, 64'd0, 4'h3, 1'b0);
        check("cmovle_cnd",   {63'd0, ex_if.e_Cnd},   64'd0);
        check("cmovle_destE", {60'd0, ex_if.e_destE}, 64'hF);
        check("cmovle_valE",  ex_if.e_valE,           64'd9);
        tick();
        check("cmovle_MdestE",{60'd0, ex_if.M_destE}, 64'hF);
        drive(4'h2, 4'h6, 64'd9, 64'd0, 64'd0, 4'h3, 1'b0);
        check("cmovg_destE",  {60'd0, ex_if.e_destE}, 64'h3);
        drive(4'h2, 4'h7, 64'd9, 64'd0, 64'd0, 4'h3, 1'b0);
        check("cmov7_cnd",    {63'd0, ex_if.e_Cnd},   64'd0);
        drive(4'h2, 4'h0, 64'd9, 64'd0, 64'd0, 4'h3, 1'b0);
        check("rrmov_valE",   ex_if.e_valE,           64'd9);
        check("rrmov_destE",  {60'd0, ex_if.e_destE}, 64'h3);
        check("rrmov_cnd",    {63'd0, ex_if.e_Cnd},   64'd1);

        drive(4'hA, 4'h0, 64'd0, 64'd100, 64'd0, 4'h4, 1'b0);
        check("push_valE", ex_if.e_valE, 64'd92);
        drive(4'h8, 4'h0, 64'd0, 64'd100, 64'd0, 4'h4, 1'b0);
        check("call_valE", ex_if.e_valE, 64'd92);
        drive(4'hB, 4'h0, 64'd0, 64'd100, 64'd0, 4'h4, 1'b0);
        check("pop_valE", ex_if.e_valE, 64'd108);
        drive(4'h4, 4'h0, 64'd0, 64'd2, 64'd1, 4'hF, 1'b0);
        check("rmmov_valE", ex_if.e_valE, 64'd3);
        drive(4'h3, 4'h0, 64'd7, 64'd7, 64'h55, 4'h1, 1'b0);
        check("irmov_valE", ex_if.e_valE, 64'h55);
        drive(4'h0, 4'h0, 64'd7, 64'd7, 64'h55, 4'h1, 1'b0);
        check("halt_valE", ex_if.e_valE, 64'd0);

        // reset mid-operation
        drive(4'h6, 4'h1, 64'd1, 64'd9, 64'd0, 4'h2, 1'b1);
        tick();
        check("pre_rst_icode", {60'd0, ex_if.M_icode}, 64'h6);
        rst = 1'b1;
        ex_if.E_stat = 4'b0100;
        tick();
        check("midrst_icode", {60'd0, ex_if.M_icode}, 64'h1);
        check("midrst_stat",  {60'd0, ex_if.M_stat},  64'h8);
        check("midrst_destE", {60'd0, ex_if.M_destE}, 64'hF);
        check("midrst_cc",    {61'd0, ex_if.cc_in},   64'b001);
        rst = 1'b0;
        drive(4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 1'b0);
        tick();
        check("hlt_stat", {60'd0, ex_if.M_stat}, 64'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
